// File: rtl/ulx3s_pll_reset_seq.sv
// Reset sequencer for the ULX3S PLL output domain: synchronizes and filters the PLL lock flag,
// holds reset through a settling period, and counts lock losses.
module ulx3s_pll_reset_seq #(
  parameter int unsigned LOCK_FILTER = 1024,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter int unsigned DROP_FILTER = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pll_locked,
  output logic             out_reset,
  output logic             out_resetn,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [1:0]       state
);

  localparam int unsigned MaxCnt = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned DcntW  = (DROP_FILTER > 1) ? $clog2(DROP_FILTER) : 1;

  localparam logic [CntW-1:0]  FilterLast = CntW'(LOCK_FILTER - 1);
  localparam logic [CntW-1:0]  HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [DcntW-1:0] DropLast   = DcntW'(DROP_FILTER - 1);
  localparam logic [CNT_W-1:0] LossMax    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StWait   = 2'd0,
    StFilter = 2'd1,
    StHold   = 2'd2,
    StRun    = 2'd3
  } state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic [CntW-1:0]  cnt_q;
  logic [DcntW-1:0] dcnt_q;
  logic [CNT_W-1:0] loss_q;

  // Two-flop synchronizer; only locked_s is used downstream.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StWait;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      loss_q  <= '0;
    end else begin
      unique case (state_q)
        StWait: begin
          if (locked_s) begin
            state_q <= StFilter;
            cnt_q   <= '0;
          end
        end
        StFilter: begin
          if (!locked_s) begin
            state_q <= StWait;
          end else if (cnt_q == FilterLast) begin
            state_q <= StHold;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (!locked_s) begin
            state_q <= StWait;
          end else if (cnt_q == HoldLast) begin
            state_q <= StRun;
            dcnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (locked_s) begin
            dcnt_q <= '0;
          end else if (dcnt_q == DropLast) begin
            state_q <= StWait;
            dcnt_q  <= '0;
            if (loss_q != LossMax) begin
              loss_q <= loss_q + 1'b1;
            end
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: state_q <= StWait;
      endcase
    end
  end

  // Outputs decode the state register only, so lock glitches never reach them directly.
  assign out_reset  = (state_q != StRun);
  assign out_resetn = ~out_reset;
  assign ready      = (state_q == StRun);
  assign loss_count = loss_q;
  assign state      = state_q;

endmodule

// File: tb/tb_ulx3s_pll_reset_seq.sv
// Self-checking bench for ulx3s_pll_reset_seq using a streak-counting reference model.
module tb_ulx3s_pll_reset_seq;

  localparam int unsigned LF    = 16;
  localparam int unsigned HC    = 8;
  localparam int unsigned DF    = 4;
  localparam int unsigned CW    = 2;
  localparam int          LMAX  = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          pll_locked = 1'b0;
  logic          out_reset;
  logic          out_resetn;
  logic          ready;
  logic [CW-1:0] loss_count;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  // Reference model: lock seen through a 2-edge delay, state from run lengths.
  logic m_s0, m_s1;
  int   m_streak;
  bit   m_run;
  int   m_low;
  int   m_loss;

  ulx3s_pll_reset_seq #(
    .LOCK_FILTER(LF),
    .HOLD_CYCLES(HC),
    .DROP_FILTER(DF),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .pll_locked(pll_locked),
    .out_reset(out_reset),
    .out_resetn(out_resetn),
    .ready(ready),
    .loss_count(loss_count),
    .state(state)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] m_state();
    if (m_run) return 2'd3;
    if (m_streak == 0) return 2'd0;
    if (m_streak <= int'(LF)) return 2'd1;
    return 2'd2;
  endfunction

  task automatic model_reset();
    m_s0 = 1'b0;
    m_s1 = 1'b0;
    m_streak = 0;
    m_run = 1'b0;
    m_low = 0;
    m_loss = 0;
  endtask

  task automatic model_edge(input logic pl);
    logic ls;
    ls = m_s1;
    m_s1 = m_s0;
    m_s0 = pl;
    if (!m_run) begin
      if (!ls) begin
        m_streak = 0;
      end else begin
        m_streak++;
        if (m_streak == int'(LF + HC + 1)) begin
          m_run = 1'b1;
          m_streak = 0;
          m_low = 0;
        end
      end
    end else if (ls) begin
      m_low = 0;
    end else begin
      m_low++;
      if (m_low == int'(DF)) begin
        m_run = 1'b0;
        m_low = 0;
        if (m_loss < LMAX) m_loss++;
      end
    end
  endtask

  // Drive one input sample, let one rising edge pass, and advance the model.
  task automatic step(input logic pl);
    pll_locked = pl;
    @(posedge clock);
    model_edge(pl);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pll_locked = 1'b0;
    repeat (2) @(posedge clock);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (state !== 2'd0 || out_reset !== 1'b1 || out_resetn !== 1'b0 || ready !== 1'b0 ||
        loss_count !== '0) begin
      errors++;
      $display("FAIL reset_no_clock: state=%0d out_reset=%b out_resetn=%b ready=%b loss=%0d, want 0 1 0 0 0",
               state, out_reset, out_resetn, ready, loss_count);
    end
    pll_locked = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (state !== 2'd0 || out_reset !== 1'b1 || ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_held cyc %0d: state=%0d out_reset=%b ready=%b, want 0 1 0",
                 i, state, out_reset, ready);
      end
    end
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_clean_lock();
    logic [1:0] want;
    do_reset();
    for (int e = 0; e < 30; e++) begin
      step(1'b1);
      checks++;
      if (state !== m_state() || out_reset !== (m_state() != 2'd3) ||
          out_resetn !== (m_state() == 2'd3) || ready !== (m_state() == 2'd3)) begin
        errors++;
        $display("FAIL clean_lock edge %0d: state=%0d out_reset=%b ready=%b, want state=%0d",
                 e, state, out_reset, ready, m_state());
      end
      if (e == 1 || e == 2 || e == 17 || e == 18 || e == 25 || e == 26) begin
        case (e)
          1:       want = 2'd0;
          2, 17:   want = 2'd1;
          18, 25:  want = 2'd2;
          default: want = 2'd3;
        endcase
        checks++;
        if (state !== want) begin
          errors++;
          $display("FAIL clean_lock_milestone edge %0d: state=%0d, want %0d", e, state, want);
        end
      end
    end
  endtask

  task automatic test_filter_abort();
    do_reset();
    for (int e = 0; e < 40; e++) begin
      step(e == 10 ? 1'b0 : 1'b1);
      checks++;
      if (state !== m_state() || ready !== (m_state() == 2'd3)) begin
        errors++;
        $display("FAIL filter_abort edge %0d: state=%0d ready=%b, want %0d",
                 e, state, ready, m_state());
      end
      if (e == 11 || e == 12 || e == 36 || e == 37) begin
        checks++;
        if (state !== ((e == 11) ? 2'd1 : (e == 12) ? 2'd0 : (e == 36) ? 2'd2 : 2'd3)) begin
          errors++;
          $display("FAIL filter_abort_milestone edge %0d: state=%0d", e, state);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int len;
    for (int r = 0; r < 4; r++) begin
      len = (r == 0) ? 3 : int'($urandom_range(1, DF - 1));
      for (int i = 0; i < len; i++) step(1'b0);
      for (int i = 0; i < 4; i++) begin
        step(1'b1);
        checks++;
        if (state !== 2'd3 || out_reset !== 1'b0 || loss_count !== CW'(m_loss) ||
            m_state() != 2'd3) begin
          errors++;
          $display("FAIL glitch len %0d: state=%0d out_reset=%b loss=%0d, want 3 0 %0d",
                   len, state, out_reset, loss_count, m_loss);
        end
      end
    end
  endtask

  task automatic test_real_loss();
    bit seen_run;
    for (int e = 0; e < 6; e++) begin
      step(1'b0);
      checks++;
      if (state !== ((e < 5) ? 2'd3 : 2'd0) || out_reset !== (e >= 5)) begin
        errors++;
        $display("FAIL real_loss edge %0d: state=%0d out_reset=%b", e, state, out_reset);
      end
    end
    checks++;
    if (loss_count !== CW'(1)) begin
      errors++;
      $display("FAIL real_loss_count: loss=%0d, want 1", loss_count);
    end
    seen_run = 1'b0;
    for (int e = 0; e < 40 && !seen_run; e++) begin
      step(1'b1);
      if (state === 2'd3) seen_run = 1'b1;
    end
    checks++;
    if (!seen_run || m_state() != 2'd3) begin
      errors++;
      $display("FAIL real_loss_relock: state=%0d, want 3 within 40 edges", state);
    end
  endtask

  task automatic test_saturation();
    int want [5];
    want = '{1, 2, 3, 3, 3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      repeat (30) step(1'b1);
      repeat (6) step(1'b0);
      checks++;
      if (loss_count !== CW'(want[k]) || state !== 2'd0) begin
        errors++;
        $display("FAIL saturation loss %0d: loss=%0d state=%0d, want %0d and 0",
                 k + 1, loss_count, state, want[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (30) step(1'b1);
    checks++;
    if (state !== 2'd3 || loss_count === '0) begin
      errors++;
      $display("FAIL async_reset_setup: state=%0d loss=%0d, want 3 and nonzero", state, loss_count);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (out_reset !== 1'b1 || ready !== 1'b0 || loss_count !== '0 || state !== 2'd0) begin
      errors++;
      $display("FAIL async_reset_immediate: out_reset=%b ready=%b loss=%0d state=%0d, want 1 0 0 0",
               out_reset, ready, loss_count, state);
    end
    #1 resetn = 1'b1;
    model_reset();
    for (int e = 0; e < 30; e++) begin
      step(1'b1);
      checks++;
      if (state !== m_state()) begin
        errors++;
        $display("FAIL async_reset_restart edge %0d: state=%0d, want %0d", e, state, m_state());
      end
    end
  endtask

  task automatic test_random();
    int len;
    logic lvl;
    lvl = 1'b1;
    for (int b = 0; b < 80; b++) begin
      len = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        step(lvl);
        checks++;
        if (state !== m_state() || out_reset !== (m_state() != 2'd3) ||
            out_resetn !== (m_state() == 2'd3) || ready !== (m_state() == 2'd3) ||
            loss_count !== CW'(m_loss)) begin
          errors++;
          $display("FAIL random burst %0d: state=%0d out_reset=%b ready=%b loss=%0d, want state=%0d loss=%0d",
                   b, state, out_reset, ready, loss_count, m_state(), m_loss);
        end
      end
      lvl = ~lvl;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_lock();
    test_glitch();
    test_real_loss();
    test_filter_abort();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
